ip2_testx_scanchain_reg: RTL and testbench

- Holds the 768-bit scan-chain pattern and feeds it bit-serially to the scan-chain test state machines (test1 and siblings).
- Captures the ASIC scan_out stream into a capture register and compares the captured data against the written pattern.
- Sits between the host configuration word interface and the muxed sm_testx_o_* control bus from the active test state machine.

---
 rtl/ip2_testx_scanchain_reg.sv | 184 ++++++++++++++++++
 tb/tb_ip2_testx_scanchain_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ip2_testx_scanchain_reg.sv
// Scan-chain pattern/capture register: serialises the pattern to the test FSMs and compares the captured scan_out stream.
// Optional SCANCHAIN_ERRCNT_EN: bit-serial compare with an error counter output.
module ip2_testx_scanchain_reg #(
    parameter int CHAIN_LEN = 768,
    parameter int WORD_W    = 32,
    parameter int N_WORDS   = CHAIN_LEN / WORD_W,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_wr_en,
    input  logic [4:0]        cfg_wr_addr,
    input  logic [WORD_W-1:0] cfg_wr_data,
    output logic              cfg_wr_busy,
    input  logic [4:0]        cfg_rd_addr,
    output logic [WORD_W-1:0] cfg_rd_data,
    input  logic              sm_testx_o_scanchain_reg_load,
    input  logic              sm_testx_o_scanchain_reg_shift,
    input  logic              scan_out,
    output logic              sm_testx_i_scanchain_reg_bit0,
    output logic [CNT_W-1:0]  sm_testx_i_scanchain_reg_shift_cnt,
    output logic [CNT_W-1:0]  sm_testx_i_scanchain_reg_shift_cnt_max,
    output logic              scanchain_cmp_done,
    output logic              scanchain_cmp_mismatch,
    output logic [1:0]        scanchain_state
`ifdef SCANCHAIN_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]  scanchain_err_cnt
`endif
);

    // state      | meaning
    // IDLE_SC    | waiting for a load, host writes accepted
    // SHIFT_SC   | shifting pattern out / scan_out in
    // COMPARE_SC | comparing capture against pattern
    // DONE_SC    | results held, host writes accepted
    typedef enum logic [1:0] {
        IDLE_SC    = 2'd0,
        SHIFT_SC   = 2'd1,
        COMPARE_SC = 2'd2,
        DONE_SC    = 2'd3
    } sc_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

    sc_state_t              state_q, state_d;
    logic [CHAIN_LEN-1:0]   pattern_q;
    logic [CHAIN_LEN-1:0]   work_q;
    logic [CHAIN_LEN-1:0]   capture_q;
    logic [CNT_W-1:0]       shift_cnt_q;
    logic [WORD_W-1:0]      rd_word;
    logic                   do_load, do_shift, cmp_last, wr_ok, busy_d;
    logic                   soft_clr;

`ifdef SCANCHAIN_ERRCNT_EN
    logic [CNT_W-1:0]       cmp_idx_q;
    logic [CNT_W-1:0]       err_cnt_q;
    logic                   bit_diff;

    assign bit_diff = capture_q[cmp_idx_q] != pattern_q[cmp_idx_q];
    assign scanchain_err_cnt = err_cnt_q;
`endif

    assign soft_clr = reset || !enable;

    always_ff @(posedge clk) begin
        if (soft_clr) state_q <= IDLE_SC;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_shift = 1'b0;
        cmp_last = 1'b0;
        case (state_q)
            IDLE_SC, DONE_SC: begin
                if (sm_testx_o_scanchain_reg_load) begin
                    do_load = 1'b1;
                    state_d = SHIFT_SC;
                end
            end
            SHIFT_SC: begin
                if (sm_testx_o_scanchain_reg_load) begin
                    do_load = 1'b1;
                end else if (shift_cnt_q == CNT_MAX) begin
                    state_d = COMPARE_SC;
                end else if (sm_testx_o_scanchain_reg_shift) begin
                    do_shift = 1'b1;
                end
            end
            COMPARE_SC: begin
`ifdef SCANCHAIN_ERRCNT_EN
                if (cmp_idx_q == CNT_W'(CHAIN_LEN - 1)) begin
                    cmp_last = 1'b1;
                    state_d  = DONE_SC;
                end
`else
                cmp_last = 1'b1;
                state_d  = DONE_SC;
`endif
            end
            default: state_d = IDLE_SC;
        endcase
    end

    assign busy_d = (state_d == SHIFT_SC) || (state_d == COMPARE_SC);
    assign wr_ok  = cfg_wr_en && enable && ((state_q == IDLE_SC) || (state_q == DONE_SC));

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (cfg_rd_addr == 5'(k)) rd_word = capture_q[k*WORD_W +: WORD_W];
        end
    end

    // Pattern survives enable low; only a hard reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
        end else begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (wr_ok && cfg_wr_addr == 5'(k)) pattern_q[k*WORD_W +: WORD_W] <= cfg_wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (soft_clr) begin
            work_q                 <= '0;
            capture_q              <= '0;
            shift_cnt_q            <= '0;
            cfg_rd_data            <= '0;
            cfg_wr_busy            <= 1'b0;
            scanchain_cmp_done     <= 1'b0;
            scanchain_cmp_mismatch <= 1'b0;
`ifdef SCANCHAIN_ERRCNT_EN
            cmp_idx_q              <= '0;
            err_cnt_q              <= '0;
`endif
        end else begin
            cfg_wr_busy <= busy_d;
            cfg_rd_data <= rd_word;
            if (do_load) begin
                work_q                 <= pattern_q;
                capture_q              <= '0;
                shift_cnt_q            <= '0;
                scanchain_cmp_done     <= 1'b0;
                scanchain_cmp_mismatch <= 1'b0;
`ifdef SCANCHAIN_ERRCNT_EN
                cmp_idx_q              <= '0;
                err_cnt_q              <= '0;
`endif
            end else if (do_shift) begin
                work_q      <= {1'b0, work_q[CHAIN_LEN-1:1]};
                capture_q   <= {scan_out, capture_q[CHAIN_LEN-1:1]};
                shift_cnt_q <= shift_cnt_q + CNT_W'(1);
            end
`ifdef SCANCHAIN_ERRCNT_EN
            if (state_q == COMPARE_SC) begin
                cmp_idx_q <= cmp_idx_q + CNT_W'(1);
                if (bit_diff) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            // Fold in the final bit, whose increment lands in the same clock.
            if (cmp_last) begin
                scanchain_cmp_done     <= 1'b1;
                scanchain_cmp_mismatch <= (err_cnt_q != '0) || bit_diff;
            end
`else
            if (cmp_last) begin
                scanchain_cmp_done     <= 1'b1;
                scanchain_cmp_mismatch <= capture_q != pattern_q;
            end
`endif
        end
    end

    assign sm_testx_i_scanchain_reg_bit0          = work_q[0];
    assign sm_testx_i_scanchain_reg_shift_cnt     = shift_cnt_q;
    assign sm_testx_i_scanchain_reg_shift_cnt_max = CNT_MAX;
    assign scanchain_state                        = state_q;

endmodule

// File: tb/tb_ip2_testx_scanchain_reg.sv
// Directed self-checking bench for ip2_testx_scanchain_reg (honours SCANCHAIN_ERRCNT_EN when defined).
`timescale 1ns/1ps
module tb_ip2_testx_scanchain_reg;

    logic        clk = 1'b0;
    logic        reset, enable, cfg_wr_en, load, shift, scan_out;
    logic [4:0]  cfg_wr_addr, cfg_rd_addr;
    logic [31:0] cfg_wr_data, cfg_rd_data;
    logic        cfg_wr_busy, bit0, cmp_done, cmp_mismatch;
    logic [9:0]  shift_cnt, shift_cnt_max;
    logic [1:0]  state;
`ifdef SCANCHAIN_ERRCNT_EN
    logic [9:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cmp_entries = 0;
    logic [1:0] prev_state = 2'd0;

    always #1.25 clk = ~clk;

    ip2_testx_scanchain_reg dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_wr_busy(cfg_wr_busy), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
        .sm_testx_o_scanchain_reg_load(load), .sm_testx_o_scanchain_reg_shift(shift),
        .scan_out(scan_out), .sm_testx_i_scanchain_reg_bit0(bit0),
        .sm_testx_i_scanchain_reg_shift_cnt(shift_cnt),
        .sm_testx_i_scanchain_reg_shift_cnt_max(shift_cnt_max),
        .scanchain_cmp_done(cmp_done), .scanchain_cmp_mismatch(cmp_mismatch),
        .scanchain_state(state)
`ifdef SCANCHAIN_ERRCNT_EN
        , .scanchain_err_cnt(err_cnt)
`endif
    );

    always @(posedge clk) begin
        prev_state <= state;
        if (state == 2'd2 && prev_state != 2'd2) cmp_entries <= cmp_entries + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        tick(1);
        cfg_wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cfg_rd_addr = a;
        tick(1);
        chk(tag, cfg_rd_data, exp);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    // loop=1 feeds bit0 back as scan_out; returns count of bit0 values differing from A5 pattern order.
    task automatic do_shifts(input int n, input bit loop, output int seq_err);
        logic [31:0] pat;
        pat = 32'hA5A5A5A5;
        seq_err = 0;
        for (int i = 0; i < n; i++) begin
            if (i < 768 && bit0 !== pat[i % 32]) seq_err++;
            scan_out = loop ? bit0 : 1'b0;
            shift = 1'b1;
            tick(1);
            shift = 1'b0;
            tick(3);
        end
    endtask

    task automatic wait_done(input string tag);
        int waited;
        waited = 0;
        while (cmp_done !== 1'b1 && waited < 2000) begin
            tick(1);
            waited++;
        end
        chk(tag, {31'd0, cmp_done}, 32'd1);
    endtask

    initial begin
        int serr;
        int entries0;
        reset = 1'b1; enable = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_rd_addr = '0; load = 1'b0; shift = 1'b0; scan_out = 1'b0;
        tick(3);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cnt", {22'd0, shift_cnt}, 32'd0);
        chk("rst_cnt_max", {22'd0, shift_cnt_max}, 32'd768);
        chk("rst_done", {31'd0, cmp_done}, 32'd0);
        chk("rst_busy", {31'd0, cfg_wr_busy}, 32'd0);
        chk("rst_bit0", {31'd0, bit0}, 32'd0);
        chk("rst_rd", cfg_rd_data, 32'd0);
        reset = 1'b0;
        tick(1);

        // 1: loopback, full pass
        for (int k = 0; k < 24; k++) wr(5'(k), 32'hA5A5A5A5);
        pulse_load();
        chk("t1_state_shift", {30'd0, state}, 32'd1);
        chk("t1_busy", {31'd0, cfg_wr_busy}, 32'd1);
        chk("t1_bit0_first", {31'd0, bit0}, 32'd1);
        do_shifts(768, 1'b1, serr);
        chk("t1_bit0_seq", serr, 32'd0);
        chk("t1_cnt", {22'd0, shift_cnt}, 32'd768);
        wait_done("t1_done");
        chk("t1_mismatch", {31'd0, cmp_mismatch}, 32'd0);
        chk("t1_state_done", {30'd0, state}, 32'd3);
        chk("t1_busy_done", {31'd0, cfg_wr_busy}, 32'd0);
        rd_chk("t1_rd_w0", 5'd0, 32'hA5A5A5A5);
        rd_chk("t1_rd_w23", 5'd23, 32'hA5A5A5A5);
        rd_chk("t1_rd_w24", 5'd24, 32'd0);

        // 2: scan_out stuck at 0
        pulse_load();
        chk("t2_done_clr", {31'd0, cmp_done}, 32'd0);
        do_shifts(768, 1'b0, serr);
        wait_done("t2_done");
        chk("t2_mismatch", {31'd0, cmp_mismatch}, 32'd1);
`ifdef SCANCHAIN_ERRCNT_EN
        chk("t2_err_cnt", {22'd0, err_cnt}, 32'd384);
`endif
        rd_chk("t2_rd_w0", 5'd0, 32'd0);
        wr(5'd0, 32'h12345678);
        chk("t2_wr_keep_done", {31'd0, cmp_done}, 32'd1);
        chk("t2_wr_keep_mm", {31'd0, cmp_mismatch}, 32'd1);

        // 3: over-shift saturates; compare entered once
        pulse_load();
        entries0 = cmp_entries;
        do_shifts(770, 1'b1, serr);
        wait_done("t3_done");
        chk("t3_cnt_sat", {22'd0, shift_cnt}, 32'd768);
        chk("t3_cmp_once", cmp_entries - entries0, 32'd1);
        chk("t3_mismatch", {31'd0, cmp_mismatch}, 32'd0);
        rd_chk("t3_rd_w0_new", 5'd0, 32'h12345678);
        wr(5'd0, 32'hA5A5A5A5);

        // 4: load and shift together
        pulse_load();
        do_shifts(3, 1'b1, serr);
        chk("t4_cnt3", {22'd0, shift_cnt}, 32'd3);
        chk("t4_bit0_3", {31'd0, bit0}, 32'd0);
        load = 1'b1; shift = 1'b1;
        tick(1);
        load = 1'b0; shift = 1'b0;
        chk("t4_cnt0", {22'd0, shift_cnt}, 32'd0);
        chk("t4_bit0_reload", {31'd0, bit0}, 32'd1);

        // 5: write while busy dropped
        chk("t5_busy", {31'd0, cfg_wr_busy}, 32'd1);
        wr(5'd3, 32'hFFFFFFFF);
        do_shifts(768, 1'b1, serr);
        wait_done("t5_done");
        chk("t5_mismatch", {31'd0, cmp_mismatch}, 32'd0);
        rd_chk("t5_rd_w3", 5'd3, 32'hA5A5A5A5);

        // 6: enable drop mid-sequence
        pulse_load();
        do_shifts(100, 1'b1, serr);
        chk("t6_cnt100", {22'd0, shift_cnt}, 32'd100);
        enable = 1'b0;
        tick(1);
        chk("t6_state_idle", {30'd0, state}, 32'd0);
        chk("t6_cnt0", {22'd0, shift_cnt}, 32'd0);
        chk("t6_done0", {31'd0, cmp_done}, 32'd0);
        chk("t6_bit0", {31'd0, bit0}, 32'd0);
        chk("t6_busy0", {31'd0, cfg_wr_busy}, 32'd0);
        enable = 1'b1;
        tick(1);
        wr(5'd24, 32'hFFFFFFFF);
        pulse_load();
        chk("t6_bit0_reload", {31'd0, bit0}, 32'd1);
        do_shifts(768, 1'b1, serr);
        chk("t6_bit0_seq", serr, 32'd0);
        wait_done("t6_done");
        chk("t6_mismatch", {31'd0, cmp_mismatch}, 32'd0);
        rd_chk("t6_rd_w0", 5'd0, 32'hA5A5A5A5);
        rd_chk("t6_rd_w12", 5'd12, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
